// File: rtl/emergency_pkg.sv
// Shared types and timing constants for the emergency input conditioner and the emergency FSM.
package emergency_pkg;

    typedef enum logic [1:0] {IDLE, CONFIRM_P, PRESSED, CONFIRM_R} debounce_state_t;
    typedef enum logic [2:0] {WARMUP, ARMED, QUALIFY, ACTIVE, HOLD} pir_state_t;

    localparam int unsigned CLK_HZ = 50_000_000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned DEBOUNCE_MS    = 20;
    localparam int unsigned PIR_WARMUP_MS  = 1000;
    localparam int unsigned PIR_QUALIFY_MS = 5;
    localparam int unsigned PIR_HOLD_MS    = 100;
    localparam int unsigned STUCK_MS       = 5000;

    localparam int unsigned DEBOUNCE_CYCLES_DEF    = ms_to_cycles(DEBOUNCE_MS);
    localparam int unsigned PIR_WARMUP_CYCLES_DEF  = ms_to_cycles(PIR_WARMUP_MS);
    localparam int unsigned PIR_QUALIFY_CYCLES_DEF = ms_to_cycles(PIR_QUALIFY_MS);
    localparam int unsigned PIR_HOLD_CYCLES_DEF    = ms_to_cycles(PIR_HOLD_MS);
    localparam int unsigned STUCK_CYCLES_DEF       = ms_to_cycles(STUCK_MS);

endpackage

// File: rtl/input_sync_debounce.sv
// Panic button synchronizer and debounce FSM; one strobe per accepted press, level while held.
// Stuck-button detection is built only when EIC_STUCK_DETECT_EN is defined.
module input_sync_debounce
    import emergency_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
`ifdef EIC_STUCK_DETECT_EN
    parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF,
`endif
    parameter int unsigned CNT_W           = 28,
    parameter int unsigned CNT_CEIL        = STUCK_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pulse,
    output logic level,
    output logic fault
);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_CEIL);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Button side presets to released (high) so reset never looks like a press.
    logic [SYNC_STAGES-1:0] sync;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '1;
        else       sync <= {sync[SYNC_STAGES-2:0], btn_n};
    end

    logic pressed;
    assign pressed = ~sync[SYNC_STAGES-1];

    debounce_state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             pulse_raw;
    logic             level_raw;
    logic             done;

    assign done = (cnt == DEB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (cnt_clr)             cnt <= '0;
            else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
        end
    end

    // Strobe and level drop are asserted in the confirming transition cycle itself.
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b1;
        pulse_raw  = 1'b0;
        level_raw  = 1'b0;
        case (state)
            IDLE: begin
                if (pressed) state_next = CONFIRM_P;
            end
            CONFIRM_P: begin
                if (!pressed) begin
                    state_next = IDLE;
                end else if (done) begin
                    state_next = PRESSED;
                    pulse_raw  = 1'b1;
                end else begin
                    cnt_clr = 1'b0;
                end
            end
            PRESSED: begin
                level_raw = 1'b1;
                if (!pressed) state_next = CONFIRM_R;
            end
            CONFIRM_R: begin
                if (pressed) begin
                    state_next = PRESSED;
                    level_raw  = 1'b1;
                end else if (done) begin
                    state_next = IDLE;
                end else begin
                    level_raw = 1'b1;
                    cnt_clr   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef EIC_STUCK_DETECT_EN
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);

    logic             held;
    logic [CNT_W-1:0] stuck_cnt;
    logic             fault_q;

    assign held = (state == PRESSED) || (state == CONFIRM_R);

    // Sticky while held; dropping out of the held states clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stuck_cnt <= '0;
            fault_q   <= 1'b0;
        end else if (!held) begin
            stuck_cnt <= '0;
            fault_q   <= 1'b0;
        end else begin
            if (stuck_cnt != CNT_SAT)    stuck_cnt <= stuck_cnt + 1'b1;
            if (stuck_cnt == STUCK_LAST) fault_q   <= 1'b1;
        end
    end

    assign fault = fault_q & held;
    assign pulse = pulse_raw & ~fault;
    assign level = level_raw & ~fault;
`else
    assign fault = 1'b0;
    assign pulse = pulse_raw;
    assign level = level_raw;
`endif

endmodule

// File: rtl/emergency_input_conditioner.sv
// Board-pin front end for the emergency controller: debounced panic button and qualified PIR.
// Define EIC_STUCK_DETECT_EN to build the stuck-button detector.
module emergency_input_conditioner
    import emergency_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned DEBOUNCE_CYCLES    = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned PIR_WARMUP_CYCLES  = PIR_WARMUP_CYCLES_DEF,
    parameter int unsigned PIR_QUALIFY_CYCLES = PIR_QUALIFY_CYCLES_DEF,
    parameter int unsigned PIR_HOLD_CYCLES    = PIR_HOLD_CYCLES_DEF,
    parameter int unsigned STUCK_CYCLES       = STUCK_CYCLES_DEF,
    parameter int unsigned CNT_W              = 28
) (
    input  logic clk,
    input  logic reset,
    input  logic panic_btn_n,
    input  logic danger_sense,
    output logic panic_pulse,
    output logic panic_level,
    output logic danger_valid,
    output logic pir_ready,
    output logic btn_fault
);
    // Counters saturate at the longest timeout in use, which CNT_W must be able to hold.
    localparam int unsigned CNT_CEIL = max_u(max_u(max_u(DEBOUNCE_CYCLES, PIR_WARMUP_CYCLES),
                                                   max_u(PIR_QUALIFY_CYCLES, PIR_HOLD_CYCLES)),
                                             STUCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_CEIL);
    localparam logic [CNT_W-1:0] WARMUP_LAST  = CNT_W'(PIR_WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] QUALIFY_LAST = CNT_W'(PIR_QUALIFY_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(PIR_HOLD_CYCLES - 1);

    input_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`ifdef EIC_STUCK_DETECT_EN
        .STUCK_CYCLES    (STUCK_CYCLES),
`endif
        .CNT_W           (CNT_W),
        .CNT_CEIL        (CNT_CEIL)
    ) u_btn (
        .clk   (clk),
        .reset (reset),
        .btn_n (panic_btn_n),
        .pulse (panic_pulse),
        .level (panic_level),
        .fault (btn_fault)
    );

    logic [SYNC_STAGES-1:0] sense_sync;
    logic                   sense;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sense_sync <= '0;
        else       sense_sync <= {sense_sync[SYNC_STAGES-2:0], danger_sense};
    end

    assign sense = sense_sync[SYNC_STAGES-1];

    pir_state_t       pir_state, pir_next;
    logic [CNT_W-1:0] pir_cnt;
    logic             pir_cnt_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pir_state <= WARMUP;
            pir_cnt   <= '0;
        end else begin
            pir_state <= pir_next;
            if (pir_cnt_clr)             pir_cnt <= '0;
            else if (pir_cnt != CNT_SAT) pir_cnt <= pir_cnt + 1'b1;
        end
    end

    // danger_valid rises in the cycle qualification completes; HOLD keeps it for the full stretch.
    always_comb begin
        pir_next     = pir_state;
        pir_cnt_clr  = 1'b1;
        danger_valid = 1'b0;
        pir_ready    = 1'b1;
        case (pir_state)
            WARMUP: begin
                pir_ready = 1'b0;
                if (pir_cnt == WARMUP_LAST) pir_next    = ARMED;
                else                        pir_cnt_clr = 1'b0;
            end
            ARMED: begin
                if (sense) pir_next = QUALIFY;
            end
            QUALIFY: begin
                if (!sense) begin
                    pir_next = ARMED;
                end else if (pir_cnt == QUALIFY_LAST) begin
                    pir_next     = ACTIVE;
                    danger_valid = 1'b1;
                end else begin
                    pir_cnt_clr = 1'b0;
                end
            end
            ACTIVE: begin
                danger_valid = 1'b1;
                if (!sense) pir_next = HOLD;
            end
            HOLD: begin
                danger_valid = 1'b1;
                if (sense)                         pir_next    = ACTIVE;
                else if (pir_cnt == HOLD_LAST)     pir_next    = ARMED;
                else                               pir_cnt_clr = 1'b0;
            end
            default: begin
                pir_next  = WARMUP;
                pir_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_emergency_input_conditioner.sv
// Bench for emergency_input_conditioner: run-length reference model feeding a per-cycle scoreboard.
module tb_emergency_input_conditioner;

    localparam int SYNC  = 2;
    localparam int DEB   = 8;
    localparam int WARM  = 20;
    localparam int QUAL  = 4;
    localparam int HOLDC = 10;
    localparam int STUCK = 50;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic panic_btn_n = 1'b1;
    logic danger_sense = 1'b0;
    logic panic_pulse, panic_level, danger_valid, pir_ready, btn_fault;

    emergency_input_conditioner #(
        .SYNC_STAGES        (SYNC),
        .DEBOUNCE_CYCLES    (DEB),
        .PIR_WARMUP_CYCLES  (WARM),
        .PIR_QUALIFY_CYCLES (QUAL),
        .PIR_HOLD_CYCLES    (HOLDC),
        .STUCK_CYCLES       (STUCK),
        .CNT_W              (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .panic_btn_n  (panic_btn_n),
        .danger_sense (danger_sense),
        .panic_pulse  (panic_pulse),
        .panic_level  (panic_level),
        .danger_valid (danger_valid),
        .pir_ready    (pir_ready),
        .btn_fault    (btn_fault)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // expected per cycle: {pulse, level, danger_valid, pir_ready, btn_fault}
    logic [4:0] exp_q[$];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0b expected %0b", name, $time, act, exp);
        end
    endtask

    // Reference model: raw inputs become visible SYNC-1 cycles later; behaviour is
    // expressed as run lengths of pressed / sensed / released cycles.
    logic bh[SYNC];
    logic sh[SYNC];
    int   k;
    bit   bheld;
    int   brun, brel, bhc;
    bit   pon;
    int   prun, plow;

    always @(posedge clk) begin
        logic p, s;
        logic e_pulse, e_level, e_dv, e_ready, e_fault;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) begin
                bh[i] = 1'b1;
                sh[i] = 1'b0;
            end
            k = 0; bheld = 0; brun = 0; brel = 0; bhc = 0;
            pon = 0; prun = 0; plow = 0;
        end else begin
            for (int i = SYNC - 1; i > 0; i--) begin
                bh[i] = bh[i-1];
                sh[i] = sh[i-1];
            end
            bh[0] = panic_btn_n;
            sh[0] = danger_sense;
            p = ~bh[SYNC-1];
            s = sh[SYNC-1];
            if (k < WARM) k = k + 1;

            e_pulse = 1'b0; e_level = 1'b0; e_fault = 1'b0; e_dv = 1'b0;
            if (!bheld) begin
                brun = p ? brun + 1 : 0;
                if (brun == DEB + 1) begin
                    e_pulse = 1'b1;
                    bheld = 1; brel = 0; bhc = 0;
                end
            end else begin
                brel = p ? 0 : brel + 1;
                e_level = (brel != DEB + 1);
`ifdef EIC_STUCK_DETECT_EN
                if (bhc >= STUCK) begin
                    e_fault = 1'b1;
                    e_level = 1'b0;
                end
`endif
                bhc = bhc + 1;
                if (brel == DEB + 1) begin
                    bheld = 0; brun = 0;
                end
            end

            e_ready = (k >= WARM);
            if (e_ready) begin
                if (!pon) begin
                    prun = s ? prun + 1 : 0;
                    if (prun == QUAL + 1) begin
                        e_dv = 1'b1;
                        pon = 1; plow = 0;
                    end
                end else begin
                    e_dv = 1'b1;
                    plow = s ? 0 : plow + 1;
                    if (plow == HOLDC + 1) begin
                        pon = 0; prun = 0;
                    end
                end
            end
            exp_q.push_back({e_pulse, e_level, e_dv, e_ready, e_fault});
        end
    end

    // monitor: one expected entry per clocked cycle out of reset
    always @(posedge clk) begin
        logic [4:0] e;
        #1;
        if (!reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL queue_empty at %0t: got no expected entry, required one", $time);
            end else begin
                e = exp_q.pop_front();
                chk("panic_pulse",  panic_pulse,  e[4]);
                chk("panic_level",  panic_level,  e[3]);
                chk("danger_valid", danger_valid, e[2]);
                chk("pir_ready",    pir_ready,    e[1]);
                chk("btn_fault",    btn_fault,    e[0]);
            end
        end
    end

    // driver tasks
    task automatic drive(input logic b, input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            panic_btn_n  = b;
            danger_sense = s;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_panic_pulse"},  panic_pulse,  1'b0);
        chk({tag, "_panic_level"},  panic_level,  1'b0);
        chk({tag, "_danger_valid"}, danger_valid, 1'b0);
        chk({tag, "_pir_ready"},    pir_ready,    1'b0);
        chk({tag, "_btn_fault"},    btn_fault,    1'b0);
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        // warm-up with idle inputs
        drive(1'b1, 1'b0, 25);
        // bounces shorter than the debounce window
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 3);
        drive(1'b0, 1'b0, 3);
        drive(1'b1, 1'b0, 15);
        // clean press and release
        drive(1'b0, 1'b0, 20);
        drive(1'b1, 1'b0, 20);
        // PIR: short pulse, qualified pulse, re-rise during hold
        drive(1'b1, 1'b1, 3);
        drive(1'b1, 1'b0, 10);
        drive(1'b1, 1'b1, 6);
        drive(1'b1, 1'b0, 25);
        drive(1'b1, 1'b1, 8);
        drive(1'b1, 1'b0, 5);
        drive(1'b1, 1'b1, 3);
        drive(1'b1, 1'b0, 30);
        // long hold for stuck-button behaviour
        drive(1'b0, 1'b0, 60);
        drive(1'b1, 1'b0, 20);

        // randomized segments on both inputs
        for (int i = 0; i < 120; i++) begin
            logic b, s;
            int n;
            b = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 14));
            drive(b, s, n);
        end

        // asynchronous reset with button held and danger active
        drive(1'b1, 1'b0, 30);
        drive(1'b0, 1'b1, 30);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 chk_all_zero("async_reset");
        repeat (2) @(negedge clk);
        panic_btn_n  = 1'b1;
        danger_sense = 1'b1;
        reset        = 1'b0;
        // sensor high through warm-up, then released
        drive(1'b1, 1'b1, 35);
        drive(1'b1, 1'b0, 20);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
